round_timer: RTL
================

ROUND_TIMER -- requirements
Module: round_timer

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchroniser flops on divided_clk (legal 2..4).
REQ-002 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 divided_clk  input  1  slow clock from clk_divider, treated as data; one rising edge = one second.
REQ-005 start  input  1  level; load load_tens/load_ones and begin counting.
REQ-006 pause  input  1  level; freezes counting while high.
REQ-007 load_tens  input  4  BCD tens digit of start value.
REQ-008 load_ones  input  4  BCD ones digit of start value.
REQ-009 secs_tens  output  4  BCD tens digit of remaining time.
REQ-010 secs_ones  output  4  BCD ones digit of remaining time.
REQ-011 state  output  2  IDLE=0, RUN=1, PAUSED=2, EXPIRED=3.
REQ-012 running  output  1  high iff state==RUN.
REQ-013 tick  output  1  one-cycle pulse per detected divided_clk rising edge.
REQ-014 expired  output  1  one-cycle pulse on entry to EXPIRED.

Function
REQ-015 divided_clk passes through SYNC_STAGES flops then one history flop; tick = last sync stage AND NOT history flop.
REQ-016 Edge latency: divided_clk first sampled high at edge N -> tick high in cycle after edge N+SYNC_STAGES-1 (N+1 for default); exactly one cycle per edge, none for edges shorter than one clk_in period that are missed.
REQ-017 Load: load digit >9 clamps to 9; loaded value visible on secs_* the cycle after start sampled.
REQ-018 IDLE: start -> load, go RUN; start with 00 -> load 00, go EXPIRED with expired pulse.
REQ-019 RUN: tick with value>00 -> BCD decrement; ones==0 -> ones=9, tens-1; else ones-1.
REQ-020 RUN: decrement producing 00 -> state EXPIRED, expired high in same cycle 00 appears.
REQ-021 RUN: pause high -> PAUSED; tick sampled same cycle as pause is discarded (pause priority).
REQ-022 PAUSED: ticks ignored, digits held; pause low -> RUN.
REQ-023 RUN/PAUSED: start -> reload, go RUN (or EXPIRED if 00); start beats tick and pause in same cycle.
REQ-024 EXPIRED: digits held 00; ticks ignored; start -> reload as in IDLE.
REQ-025 start held high: reload every cycle, no decrement until start falls.
REQ-026 Digits never go below 00; no wrap from 00 to 99.
REQ-027 All outputs registered except tick (derived from registered sync/history flops, glitch-free).

Reset
REQ-028 rst sampled high: state=IDLE, secs_tens=0, secs_ones=0, running=0, expired=0, all sync/history flops=0, tick=0 the following cycle.
REQ-029 rst has priority over start, pause and tick in the same cycle; mid-count reset discards remaining time.
REQ-030 divided_clk already high at reset release may produce one tick; state IDLE ignores it.

Verification
REQ-031 rst 2 cycles, start with 0/5, 5 divided_clk edges spaced 10 clk_in -> secs 04,03,02,01,00; expired single pulse with 00; state=3.
REQ-032 Start 1/0, one edge -> secs 09 (borrow); next edge -> 08.
REQ-033 Start 3/0, pause high across 3 edges -> secs stay 30, state=2; pause low, 1 edge -> 29.
REQ-034 Start 1/2 then assert rst during RUN -> next cycle all outputs at reset values; later edges leave secs 00, state 0.
REQ-035 Start with 0/0 -> state 3, expired 1 cycle; start with load 12/15 (invalid) -> secs 99 (clamped).
REQ-036 Start asserted coincident with tick in RUN at 07, load 2/0 -> secs 20, no decrement that cycle.

Source files
------------

// File: rtl/round_timer.sv
`default_nettype none
// ============================================================================
// Module   : round_timer
// Brief    : BCD seconds countdown paced by a synchronised divided_clk edge.
// Revision : 1.0 - initial release
// ============================================================================
module round_timer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       divided_clk,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic [1:0] state,
    output logic       running,
    output logic       tick,
    output logic       expired
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] C_MAX_DIGIT = 4'd9;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    state_t                 r_state;
    state_t                 w_next_state;
    logic [3:0]             w_next_tens;
    logic [3:0]             w_next_ones;
    logic                   w_next_expired;
    logic [3:0]             w_load_tens;
    logic [3:0]             w_load_ones;
    logic                   w_load_zero;
    logic                   w_nonzero;
    logic                   w_last_second;

    // divided_clk is asynchronous data: synchronise, then detect its rising edge
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], divided_clk};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign tick = r_sync[SYNC_STAGES-1] & ~r_hist;

    assign w_load_tens   = (load_tens > C_MAX_DIGIT) ? C_MAX_DIGIT : load_tens;
    assign w_load_ones   = (load_ones > C_MAX_DIGIT) ? C_MAX_DIGIT : load_ones;
    assign w_load_zero   = (w_load_tens == 4'd0) && (w_load_ones == 4'd0);
    assign w_nonzero     = (secs_tens != 4'd0) || (secs_ones != 4'd0);
    assign w_last_second = (secs_tens == 4'd0) && (secs_ones == 4'd1);

    // start outranks pause and tick in every state
    always_comb begin
        w_next_state   = r_state;
        w_next_tens    = secs_tens;
        w_next_ones    = secs_ones;
        w_next_expired = 1'b0;
        if (start) begin
            w_next_tens = w_load_tens;
            w_next_ones = w_load_ones;
            if (w_load_zero) begin
                w_next_state   = ST_EXPIRED;
                w_next_expired = (r_state != ST_EXPIRED);
            end else begin
                w_next_state = ST_RUN;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (pause) begin
                        w_next_state = ST_PAUSED;
                    end else if (tick && w_nonzero) begin
                        if (secs_ones == 4'd0) begin
                            w_next_ones = C_MAX_DIGIT;
                            w_next_tens = secs_tens - 4'd1;
                        end else begin
                            w_next_ones = secs_ones - 4'd1;
                        end
                        if (w_last_second) begin
                            w_next_state   = ST_EXPIRED;
                            w_next_expired = 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        w_next_state = ST_RUN;
                    end
                end
                default: begin
                    w_next_state = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            secs_tens <= 4'd0;
            secs_ones <= 4'd0;
            running   <= 1'b0;
            expired   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            secs_tens <= w_next_tens;
            secs_ones <= w_next_ones;
            running   <= (w_next_state == ST_RUN);
            expired   <= w_next_expired;
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire
